// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, branch flush, data-memory wait
// handling with timeout fault, and a saturating stall-cycle performance counter.
module hazard_ctrl #(
    parameter int CNT_W    = 32,
    parameter int WAIT_MAX = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_addr_D,
    input  logic [4:0]       rs2_addr_D,
    input  logic             rs1_used_D,
    input  logic             rs2_used_D,
    input  logic [4:0]       rd_addr_E,
    input  logic             mem_read_E,
    input  logic             branch_taken_E,
    input  logic             dmem_req_M,
    input  logic             dmem_ack,
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_E,
    output logic             stall_M,
    output logic             flush_D,
    output logic             flush_E,
    output logic             flush_W,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WAIT_W = $clog2(WAIT_MAX + 1);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t            state, state_nx;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_stall;
    logic              load_use;
    logic              timeout;

    // Hazard detection and the timeout condition (last unacked MEM_WAIT cycle)
    always_comb begin
        mem_stall = (state == MEM_WAIT) || (dmem_req_M && !dmem_ack);
        load_use  = mem_read_E && (rd_addr_E != 5'd0) &&
                    ((rs1_used_D && (rs1_addr_D == rd_addr_E)) ||
                     (rs2_used_D && (rs2_addr_D == rd_addr_E)));
        timeout   = (state == MEM_WAIT) && !dmem_ack &&
                    (wait_cnt == WAIT_W'(WAIT_MAX - 1));
    end

    always_comb begin
        state_nx = state;
        case (state)
            RUN:      if (dmem_req_M && !dmem_ack) state_nx = MEM_WAIT;
            MEM_WAIT: if (dmem_ack || timeout)     state_nx = RUN;
            default:  state_nx = RUN;
        endcase
    end

    // Priority: memory wait, then branch redirect, then load-use bubble
    always_comb begin
        stall_F = 1'b0;
        stall_D = 1'b0;
        stall_E = 1'b0;
        stall_M = 1'b0;
        flush_D = 1'b0;
        flush_E = 1'b0;
        flush_W = 1'b0;
        if (!rst) begin
            if (mem_stall) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                stall_E = 1'b1;
                stall_M = 1'b1;
                flush_W = 1'b1;
            end else if (branch_taken_E) begin
                flush_D = 1'b1;
                flush_E = 1'b1;
            end else if (load_use) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                flush_E = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            wait_cnt     <= '0;
            mem_fault    <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state <= state_nx;
            if (state == RUN)
                wait_cnt <= '0;
            else if (!dmem_ack)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if (timeout)
                mem_fault <= 1'b1;
            if (stall_F && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: combinational priority table plus
// multi-cycle sequences for memory wait, timeout and asynchronous reset.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1_addr_D, rs2_addr_D, rd_addr_E;
    logic        rs1_used_D, rs2_used_D, mem_read_E, branch_taken_E;
    logic        dmem_req_M, dmem_ack;
    logic        stall_F, stall_D, stall_E, stall_M;
    logic        flush_D, flush_E, flush_W, mem_fault;
    logic [31:0] stall_cycles;

    int total = 0;
    int bad   = 0;

    // Expected output bits, MSB first: stall_F stall_D stall_E stall_M flush_D flush_E flush_W
    typedef struct {
        string      name;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       br;
        logic       req;
        logic       ack;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[13];

    hazard_ctrl #(.CNT_W(32), .WAIT_MAX(255)) dut (
        .clk            (clk),
        .rst            (rst),
        .rs1_addr_D     (rs1_addr_D),
        .rs2_addr_D     (rs2_addr_D),
        .rs1_used_D     (rs1_used_D),
        .rs2_used_D     (rs2_used_D),
        .rd_addr_E      (rd_addr_E),
        .mem_read_E     (mem_read_E),
        .branch_taken_E (branch_taken_E),
        .dmem_req_M     (dmem_req_M),
        .dmem_ack       (dmem_ack),
        .stall_F        (stall_F),
        .stall_D        (stall_D),
        .stall_E        (stall_E),
        .stall_M        (stall_M),
        .flush_D        (flush_D),
        .flush_E        (flush_E),
        .flush_W        (flush_W),
        .mem_fault      (mem_fault),
        .stall_cycles   (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W};
    endfunction

    task automatic applyStimulus(input vec_t v);
        rs1_addr_D     = v.rs1;
        rs2_addr_D     = v.rs2;
        rs1_used_D     = v.u1;
        rs2_used_D     = v.u2;
        rd_addr_E      = v.rd;
        mem_read_E     = v.mr;
        branch_taken_E = v.br;
        dmem_req_M     = v.req;
        dmem_ack       = v.ack;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        vec_t v;
        v = '{"idle", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0};
        applyStimulus(v);
    endtask

    task automatic setMem(input logic req, input logic ack);
        dmem_req_M = req;
        dmem_ack   = ack;
    endtask

    initial begin
        int          n;
        logic [31:0] expCnt;
        vec_t        lu;

        vecs[0]  = '{"idle",          5'd0,  5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000};
        vecs[1]  = '{"loaduse_rs1",   5'd5,  5'd0, 1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 7'b1100010};
        vecs[2]  = '{"rd_zero",       5'd0,  5'd0, 1'b1, 1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000};
        vecs[3]  = '{"rs1_unused",    5'd5,  5'd0, 1'b0, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000};
        vecs[4]  = '{"loaduse_rs2",   5'd1,  5'd7, 1'b1, 1'b1, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 7'b1100010};
        vecs[5]  = '{"rs2_unused",    5'd1,  5'd7, 1'b1, 1'b0, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000};
        vecs[6]  = '{"not_load",      5'd5,  5'd5, 1'b1, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000};
        vecs[7]  = '{"branch",        5'd0,  5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 7'b0000110};
        vecs[8]  = '{"branch_over_lu",5'd5,  5'd0, 1'b1, 1'b0, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0, 7'b0000110};
        vecs[9]  = '{"mem_over_all",  5'd5,  5'd0, 1'b1, 1'b0, 5'd5,  1'b1, 1'b1, 1'b1, 1'b0, 7'b1111001};
        vecs[10] = '{"zero_wait",     5'd0,  5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 7'b0000000};
        vecs[11] = '{"loaduse_r31",   5'd31, 5'd0, 1'b1, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1100010};
        vecs[12] = '{"addr_mismatch", 5'd4,  5'd6, 1'b1, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000};

        rst = 1'b1;
        idle();
        #1;
        checkOutput("reset_outs",  32'(outs()), 32'd0);
        checkOutput("reset_fault", 32'(mem_fault), 32'd0);
        checkOutput("reset_cnt",   stall_cycles, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Each vector is presented and removed within one low clock phase
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
            #2;
            idle();
        end
        @(negedge clk);
        #1;
        checkOutput("table_no_count", stall_cycles, 32'd0);
        expCnt = 32'd0;

        // Load-use held across one edge
        lu = vecs[1];
        @(negedge clk);
        applyStimulus(lu);
        #1;
        checkOutput("lu_seq_outs", 32'(outs()), 32'b1100010);
        @(negedge clk);
        idle();
        #1;
        expCnt = expCnt + 1;
        checkOutput("lu_seq_cnt",  stall_cycles, expCnt);
        checkOutput("lu_seq_after", 32'(outs()), 32'd0);

        // Memory wait: ack low for 3 cycles, then high
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            setMem(1'b1, (c == 3));
            #1;
            checkOutput($sformatf("memwait_c%0d", c), 32'(outs()), 32'b1111001);
        end
        @(negedge clk);
        setMem(1'b0, 1'b0);
        #1;
        expCnt = expCnt + 4;
        checkOutput("memwait_run", 32'(outs()), 32'd0);
        checkOutput("memwait_cnt", stall_cycles, expCnt);

        // Zero-wait request stays in RUN across the edge
        @(negedge clk);
        setMem(1'b1, 1'b1);
        #1;
        checkOutput("zw_outs", 32'(outs()), 32'd0);
        @(negedge clk);
        setMem(1'b0, 1'b0);
        #1;
        checkOutput("zw_next", 32'(outs()), 32'd0);
        checkOutput("zw_cnt",  stall_cycles, expCnt);

        // Timeout: one request cycle then 255 unacked MEM_WAIT cycles
        @(negedge clk);
        setMem(1'b1, 1'b0);
        #1;
        n = (stall_F === 1'b1) ? 1 : 0;
        @(negedge clk);
        setMem(1'b0, 1'b0);
        #1;
        checkOutput("to_fault_early", 32'(mem_fault), 32'd0);
        for (int c = 0; c < 400; c++) begin
            if (stall_F !== 1'b1) break;
            n++;
            @(negedge clk);
            #1;
        end
        expCnt = expCnt + 256;
        checkOutput("to_stall_len", n, 32'd256);
        checkOutput("to_fault",     32'(mem_fault), 32'd1);
        checkOutput("to_run_outs",  32'(outs()), 32'd0);
        checkOutput("to_cnt",       stall_cycles, expCnt);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            setMem(1'b0, c[0]);
        end
        #1;
        checkOutput("to_fault_sticky", 32'(mem_fault), 32'd1);
        checkOutput("to_late_ack",     32'(outs()), 32'd0);
        checkOutput("to_cnt_hold",     stall_cycles, expCnt);

        // Async reset mid-wait, between clock edges
        @(negedge clk);
        setMem(1'b1, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("ar_waiting", 32'(outs()), 32'b1111001);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("ar_outs",  32'(outs()), 32'd0);
        checkOutput("ar_cnt",   stall_cycles, 32'd0);
        checkOutput("ar_fault", 32'(mem_fault), 32'd0);
        setMem(1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("ar_release", 32'(outs()), 32'd0);
        @(negedge clk);
        setMem(1'b0, 1'b0);
        #1;
        checkOutput("ar_run",     32'(outs()), 32'd0);
        checkOutput("ar_cnt_run", stall_cycles, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL declare parameter CNT_W, default 32, width of the stall-cycle performance counter.
REQ-002 SHALL declare parameter WAIT_MAX, default 255, the maximum number of MEM_WAIT cycles before a memory fault is flagged.
REQ-003 SHALL have port clk  input  1  the only clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port rs1_addr_D  input  5  rs1 index of the instruction in decode.
REQ-006 SHALL have port rs2_addr_D  input  5  rs2 index of the instruction in decode.
REQ-007 SHALL have port rs1_used_D  input  1  decode instruction reads rs1.
REQ-008 SHALL have port rs2_used_D  input  1  decode instruction reads rs2.
REQ-009 SHALL have port rd_addr_E  input  5  destination index of the instruction in execute.
REQ-010 SHALL have port mem_read_E  input  1  execute instruction is a load.
REQ-011 SHALL have port branch_taken_E  input  1  execute resolved a taken branch or jump (redirect).
REQ-012 SHALL have port dmem_req_M  input  1  memory stage issues a data-memory request this cycle.
REQ-013 SHALL have port dmem_ack  input  1  data memory completes the outstanding request.
REQ-014 SHALL have ports stall_F, stall_D, stall_E, stall_M  output  1 each  hold the named pipeline register.
REQ-015 SHALL have ports flush_D, flush_E, flush_W  output  1 each  load a bubble (NOP, rd=0) into the named pipeline register.
REQ-016 SHALL have port mem_fault  output  1  sticky timeout flag.
REQ-017 SHALL have port stall_cycles  output  CNT_W  count of cycles with stall_F=1.

Function
REQ-018 SHALL implement an FSM with states RUN and MEM_WAIT.
REQ-019 SHALL, in RUN, transition to MEM_WAIT when dmem_req_M=1 and dmem_ack=0; otherwise it SHALL stay in RUN.
REQ-020 SHALL, in MEM_WAIT, transition to RUN on the cycle after dmem_ack=1, or on reaching the timeout of REQ-025.
REQ-021 SHALL, while in MEM_WAIT or in RUN with dmem_req_M=1 and dmem_ack=0, assert stall_F, stall_D, stall_E, stall_M and flush_W, and assert no other flush; this case has the highest priority.
REQ-022 SHALL, in RUN when REQ-021 does not apply and branch_taken_E=1, assert flush_D and flush_E with all stalls 0; a branch overrides a load-use hazard.
REQ-023 SHALL detect a load-use hazard when mem_read_E=1, rd_addr_E!=0, and (rs1_used_D and rs1_addr_D==rd_addr_E) or (rs2_used_D and rs2_addr_D==rd_addr_E).
REQ-024 SHALL, in RUN with a load-use hazard and neither REQ-021 nor REQ-022 applying, assert stall_F, stall_D and flush_E for exactly that cycle; detection is combinational, giving a one-bubble latency, after which forwarding supplies the load data.
REQ-025 SHALL count MEM_WAIT cycles in an internal wait counter that clears on entry to MEM_WAIT; when the counter reaches WAIT_MAX without an ack, it SHALL set mem_fault=1 and force the FSM back to RUN.
REQ-026 SHALL hold mem_fault at 1 until reset; a late dmem_ack arriving in RUN SHALL be ignored.
REQ-027 SHALL increment stall_cycles by 1 on every rising edge where stall_F=1, saturating at all-ones with no wrap-around.
REQ-028 SHALL drive all outputs not asserted by REQ-021 to REQ-024 to 0.
REQ-029 SHALL treat a request acked in the same cycle it is issued (dmem_req_M=1, dmem_ack=1) as zero-wait: no stall, and the FSM stays in RUN.

Reset
REQ-030 SHALL, while rst=1, force state=RUN, clear the wait counter, mem_fault=0 and stall_cycles=0, and drive all stall and flush outputs to 0, independent of clk.
REQ-031 SHALL, when reset is asserted in the middle of MEM_WAIT, abandon the wait, resume in RUN after release, and ignore any pending ack.

Verification
REQ-032 SHALL cover load-use: mem_read_E=1, rd_addr_E=5, rs1_addr_D=5, rs1_used_D=1 -> stall_F=stall_D=flush_E=1 for 1 cycle, and stall_cycles=1.
REQ-033 SHALL cover no false hazard: the same stimulus with rd_addr_E=0, or with rs1_used_D=0 -> all outputs 0.
REQ-034 SHALL cover priority: a load-use hazard with branch_taken_E=1 -> flush_D=flush_E=1 and stall_F=0; adding dmem_req_M=1 with dmem_ack=0 -> only the four stalls and flush_W are asserted.
REQ-035 SHALL cover memory wait: dmem_req_M=1 with dmem_ack low for 3 cycles, then high -> stalls asserted for 4 cycles, RUN on the next cycle, and stall_cycles=4.
REQ-036 SHALL cover timeout: dmem_ack held at 0 -> mem_fault=1 after 255 MEM_WAIT cycles, state back in RUN, and mem_fault still 1 after 10 further cycles.
REQ-037 SHALL cover async reset: rst pulsed mid-MEM_WAIT between clock edges -> outputs go to 0 immediately and stall_cycles=0.
